// File: rtl/hs_skid_reg.sv
// hs_skid_reg: valid/ready register stage with a two-entry skid buffer.
// Every output is decoded from registered state, so no combinational path
// crosses the stage in either direction. Sustains one word per cycle when
// the consumer is always ready.
module hs_skid_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_vld,
    output logic                  din_rd,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_vld,
    input  logic                  dout_rd
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DATA_WIDTH-1:0]   main_r;
    logic [DATA_WIDTH-1:0]   skid_r;

    logic                    in_xfer_s;
    logic                    out_xfer_s;
    logic                    load_main_din_s;
    logic                    load_main_skid_s;
    logic                    load_skid_s;

    // Handshake outputs depend only on the registered state (and reset).
    assign din_rd    = (state_r != ST_FULL) && !rst;
    assign dout_vld  = (state_r != ST_EMPTY);
    assign dout_data = main_r;

    assign in_xfer_s  = din_vld && din_rd;
    assign out_xfer_s = dout_vld && dout_rd;

    // Next-state and storage-load decode from the two transfer events.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_din_s  = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_nxt_s     = ST_ONE;
                    load_main_din_s = 1'b1;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    state_nxt_s     = ST_ONE;
                    load_main_din_s = 1'b1;
                end else if (in_xfer_s) begin
                    state_nxt_s = ST_FULL;
                    load_skid_s = 1'b1;
                end else if (out_xfer_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                // din_rd is low here, so only the consumer side can move.
                if (out_xfer_s) begin
                    state_nxt_s      = ST_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State register; synchronous reset discards any buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Main register feeds dout_data; loaded from din or from the skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r <= {DATA_WIDTH{1'b0}};
        end else if (load_main_din_s) begin
            main_r <= din_data;
        end else if (load_main_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid register captures the word that arrives while the output stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_r <= {DATA_WIDTH{1'b0}};
        end else if (load_skid_s) begin
            skid_r <= din_data;
        end else begin
            skid_r <= skid_r;
        end
    end

endmodule

// File: tb/tb_hs_skid_reg.sv
// Testbench for hs_skid_reg: three instances (8, 1 and 64 bits wide) share
// one handshake stimulus and are checked every cycle against a FIFO model
// of depth two held in a queue.
module tb_hs_skid_reg;

    logic        clk;
    logic        rst;
    logic        din_vld;
    logic        dout_rd;
    logic [63:0] din_data;

    logic        din_rd8,   din_rd1,   din_rd64;
    logic        dout_vld8, dout_vld1, dout_vld64;
    logic [7:0]  dout_data8;
    logic [0:0]  dout_data1;
    logic [63:0] dout_data64;

    int checks;
    int errors;

    // Reference model: words currently held by the stage, oldest first.
    logic [63:0] q[$];

    hs_skid_reg #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .din_data(din_data[7:0]), .din_vld(din_vld), .din_rd(din_rd8),
        .dout_data(dout_data8), .dout_vld(dout_vld8), .dout_rd(dout_rd)
    );

    hs_skid_reg #(.DATA_WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .din_data(din_data[0:0]), .din_vld(din_vld), .din_rd(din_rd1),
        .dout_data(dout_data1), .dout_vld(dout_vld1), .dout_rd(dout_rd)
    );

    hs_skid_reg #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_vld(din_vld), .din_rd(din_rd64),
        .dout_data(dout_data64), .dout_vld(dout_vld64), .dout_rd(dout_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all three instances against the model's view of the stage.
    task automatic check_outputs();
        logic exp_rd;
        logic exp_vld;
        exp_rd  = rst ? 1'b0 : (q.size() < 2);
        exp_vld = (q.size() > 0);
        chk("din_rd_w8",   {63'd0, din_rd8},   {63'd0, exp_rd});
        chk("din_rd_w1",   {63'd0, din_rd1},   {63'd0, exp_rd});
        chk("din_rd_w64",  {63'd0, din_rd64},  {63'd0, exp_rd});
        chk("dout_vld_w8", {63'd0, dout_vld8}, {63'd0, exp_vld});
        chk("dout_vld_w1", {63'd0, dout_vld1}, {63'd0, exp_vld});
        chk("dout_vld_w64",{63'd0, dout_vld64},{63'd0, exp_vld});
        if (exp_vld) begin
            chk("dout_data_w8",  {56'd0, dout_data8}, {56'd0, q[0][7:0]});
            chk("dout_data_w1",  {63'd0, dout_data1}, {63'd0, q[0][0]});
            chk("dout_data_w64", dout_data64,         q[0]);
        end
    endtask

    // Data of all three instances right after a reset.
    task automatic check_zero_data();
        chk("rst_data_w8",  {56'd0, dout_data8}, 64'd0);
        chk("rst_data_w1",  {63'd0, dout_data1}, 64'd0);
        chk("rst_data_w64", dout_data64,         64'd0);
    endtask

    // One clock cycle: drive, check, advance model across the edge.
    task automatic cycle(input logic v, input logic [63:0] d, input logic r, output logic accepted);
        logic in_x;
        logic out_x;
        din_vld  = v;
        din_data = d;
        dout_rd  = r;
        #1;
        check_outputs();
        in_x  = !rst && v && (q.size() < 2);
        out_x = !rst && r && (q.size() > 0);
        accepted = in_x;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
        end else begin
            if (out_x) void'(q.pop_front());
            if (in_x)  q.push_back(d);
        end
    endtask

    initial begin
        logic acc;
        int   n_acc;
        int   budget;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        din_vld  = 1'b1;
        din_data = 64'hAA;
        dout_rd  = 1'b0;

        // Reset held for two cycles while a word is offered.
        @(posedge clk);
        #1;
        cycle(1'b1, 64'hAA, 1'b0, acc);
        cycle(1'b1, 64'hAA, 1'b0, acc);
        rst = 1'b0;
        cycle(1'b0, 64'h0, 1'b0, acc);
        check_zero_data();

        // Streaming with the consumer always ready.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 64'(i), 1'b1, acc);
            chk("stream_accept", {63'd0, acc}, 64'd1);
        end
        cycle(1'b0, 64'h0, 1'b1, acc);
        cycle(1'b0, 64'h0, 1'b1, acc);

        // Stall: output blocked from the first word, third word refused.
        cycle(1'b1, 64'h11, 1'b0, acc);
        cycle(1'b1, 64'h22, 1'b0, acc);
        cycle(1'b1, 64'h33, 1'b0, acc);
        chk("stall_refuse", {63'd0, acc}, 64'd0);
        cycle(1'b1, 64'h33, 1'b0, acc);
        cycle(1'b1, 64'h33, 1'b1, acc);
        cycle(1'b1, 64'h33, 1'b1, acc);
        chk("stall_resume_accept", {63'd0, acc}, 64'd1);
        cycle(1'b0, 64'h0, 1'b1, acc);
        cycle(1'b0, 64'h0, 1'b1, acc);

        // Wide-data stall/stream pattern exercising upper bits.
        cycle(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, acc);
        cycle(1'b1, 64'h8000_0000_0000_0001, 1'b0, acc);
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, acc);
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, acc);
        cycle(1'b0, 64'h0, 1'b1, acc);
        cycle(1'b0, 64'h0, 1'b1, acc);

        // Random handshake until 1000 words are accepted.
        n_acc  = 0;
        budget = 0;
        while (n_acc < 1000 && budget < 20000) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), acc);
            if (acc) n_acc++;
            budget++;
        end
        chk("random_words_accepted", 64'(n_acc), 64'd1000);
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b1, acc);

        // Reset while both entries are occupied.
        cycle(1'b1, 64'h5A, 1'b0, acc);
        cycle(1'b1, 64'hA5, 1'b0, acc);
        cycle(1'b1, 64'hCC, 1'b0, acc);
        rst = 1'b1;
        cycle(1'b1, 64'hCC, 1'b1, acc);
        rst = 1'b0;
        cycle(1'b0, 64'h0, 1'b0, acc);
        check_zero_data();
        cycle(1'b1, 64'h77, 1'b0, acc);
        cycle(1'b0, 64'h0, 1'b1, acc);
        cycle(1'b0, 64'h0, 1'b1, acc);
        cycle(1'b0, 64'h0, 1'b1, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
